// File: rtl/counting_logic.sv
// 12-hour BCD time-of-day counter for the alarm clock: loadable, advances one
// minute per one_minute strobe, resets to 12:00 AM.
module counting_logic (
    input  logic [3:0] new_current_time_ls_min,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic       new_current_time_AM,
    input  logic       load_new_c,
    input  logic       reset,
    input  logic       clk,
    input  logic       one_minute,
    output logic [3:0] current_time_ls_min,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_hr,
    output logic       current_time_AM
);

    logic [3:0] nxt_ls_min, nxt_ms_min, nxt_ls_hr, nxt_ms_hr;
    logic       nxt_am;

    // Next time one minute later. Out-of-range digits saturate into the
    // rollover branch so a bad load can never wedge the counter.
    always_comb begin
        nxt_ls_min = current_time_ls_min;
        nxt_ms_min = current_time_ms_min;
        nxt_ls_hr  = current_time_ls_hr;
        nxt_ms_hr  = current_time_ms_hr;
        nxt_am     = current_time_AM;
        if (current_time_ls_min >= 4'd9) begin
            nxt_ls_min = 4'd0;
            if (current_time_ms_min >= 4'd5) begin
                nxt_ms_min = 4'd0;
                if (current_time_ms_hr == 4'd0) begin
                    if (current_time_ls_hr >= 4'd9) begin
                        nxt_ms_hr = 4'd1;
                        nxt_ls_hr = 4'd0;
                    end else begin
                        nxt_ls_hr = current_time_ls_hr + 4'd1;
                    end
                end else if (current_time_ms_hr == 4'd1 && current_time_ls_hr == 4'd0) begin
                    nxt_ls_hr = 4'd1;
                end else if (current_time_ms_hr == 4'd1 && current_time_ls_hr == 4'd1) begin
                    nxt_ls_hr = 4'd2;
                    nxt_am    = ~current_time_AM;
                end else begin
                    // 12 and anything beyond it wrap to 01
                    nxt_ms_hr = 4'd0;
                    nxt_ls_hr = 4'd1;
                end
            end else begin
                nxt_ms_min = current_time_ms_min + 4'd1;
            end
        end else begin
            nxt_ls_min = current_time_ls_min + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_time_ms_hr  <= 4'd1;
            current_time_ls_hr  <= 4'd2;
            current_time_ms_min <= 4'd0;
            current_time_ls_min <= 4'd0;
            current_time_AM     <= 1'b1;
        end else if (load_new_c) begin
            current_time_ms_hr  <= new_current_time_ms_hr;
            current_time_ls_hr  <= new_current_time_ls_hr;
            current_time_ms_min <= new_current_time_ms_min;
            current_time_ls_min <= new_current_time_ls_min;
            current_time_AM     <= new_current_time_AM;
        end else if (one_minute) begin
            current_time_ms_hr  <= nxt_ms_hr;
            current_time_ls_hr  <= nxt_ls_hr;
            current_time_ms_min <= nxt_ms_min;
            current_time_ls_min <= nxt_ls_min;
            current_time_AM     <= nxt_am;
        end
    end

endmodule

// File: tb/tb_counting_logic.sv
// Scoreboarded bench for counting_logic: directed time-of-day cases plus random
// load/advance/reset traffic checked against an hour-index reference model.
module tb_counting_logic;

    typedef struct packed {
        logic [3:0] mh;
        logic [3:0] lh;
        logic [3:0] mm;
        logic [3:0] lm;
        logic       am;
    } tm_t;

    logic       clk = 1'b0;
    logic       reset, load_new_c, one_minute;
    logic [3:0] n_ls_min, n_ms_min, n_ls_hr, n_ms_hr;
    logic       n_am;
    logic [3:0] c_ls_min, c_ms_min, c_ls_hr, c_ms_hr;
    logic       c_am;

    int  n_cmp = 0;
    int  n_bad = 0;
    tm_t mdl;
    tm_t exp_q[$];

    always #5 clk = ~clk;

    counting_logic dut (
        .new_current_time_ls_min(n_ls_min),
        .new_current_time_ms_min(n_ms_min),
        .new_current_time_ls_hr (n_ls_hr),
        .new_current_time_ms_hr (n_ms_hr),
        .new_current_time_AM    (n_am),
        .load_new_c             (load_new_c),
        .reset                  (reset),
        .clk                    (clk),
        .one_minute             (one_minute),
        .current_time_ls_min    (c_ls_min),
        .current_time_ms_min    (c_ms_min),
        .current_time_ls_hr     (c_ls_hr),
        .current_time_ms_hr     (c_ms_hr),
        .current_time_AM        (c_am)
    );

    function automatic tm_t mk(int mh, int lh, int mm, int lm, bit am);
        tm_t t;
        t.mh = 4'(mh); t.lh = 4'(lh); t.mm = 4'(mm); t.lm = 4'(lm); t.am = am;
        return t;
    endfunction

    // Reference: minutes roll as digits; an hour carry goes through a 0..23
    // hour index (0 = 12 AM) so AM/PM falls out of plain modular arithmetic.
    function automatic tm_t advance(tm_t s);
        tm_t r = s;
        int  h, idx;
        if (int'(s.lm) < 9) begin r.lm = s.lm + 4'd1; return r; end
        r.lm = 4'd0;
        if (int'(s.mm) < 5) begin r.mm = s.mm + 4'd1; return r; end
        r.mm = 4'd0;
        h = int'(s.mh) * 10 + ((int'(s.lh) > 9) ? 9 : int'(s.lh));
        if (h >= 12 || h == 0) h = 12;
        idx = (h % 12) + (s.am ? 0 : 12);
        idx = (idx + 1) % 24;
        r.am = (idx < 12);
        h = idx % 12;
        if (h == 0) h = 12;
        r.mh = 4'(h / 10);
        r.lh = 4'(h % 10);
        return r;
    endfunction

    function automatic tm_t dut_time();
        return {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min, c_am};
    endfunction

    // Monitor: outputs are always valid, so one expected entry per clock edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            tm_t e, a;
            e = exp_q.pop_front();
            a = dut_time();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL time @%0t got %h%h:%h%h am=%b exp %h%h:%h%h am=%b",
                         $time, a.mh, a.lh, a.mm, a.lm, a.am, e.mh, e.lh, e.mm, e.lm, e.am);
            end
        end
    end

    task automatic step(input bit r, input bit ld, input bit om, input tm_t v);
        reset = r; load_new_c = ld; one_minute = om;
        n_ms_hr = v.mh; n_ls_hr = v.lh; n_ms_min = v.mm; n_ls_min = v.lm; n_am = v.am;
        @(posedge clk);
        if (r)       mdl = mk(1, 2, 0, 0, 1'b1);
        else if (ld) mdl = v;
        else if (om) mdl = advance(mdl);
        exp_q.push_back(mdl);
        #1;
    endtask

    task automatic check_time(input string name, input tm_t e);
        tm_t a;
        @(negedge clk);
        a = dut_time();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got %h%h:%h%h am=%b exp %h%h:%h%h am=%b",
                     name, a.mh, a.lh, a.mm, a.lm, a.am, e.mh, e.lh, e.mm, e.lm, e.am);
        end
    endtask

    tm_t z;

    initial begin
        z = mk(0, 0, 0, 0, 1'b0);
        reset = 0; load_new_c = 0; one_minute = 0;
        n_ls_min = 0; n_ms_min = 0; n_ls_hr = 0; n_ms_hr = 0; n_am = 0;
        mdl = z;

        // reset from an arbitrary loaded state, then hold
        step(0, 1, 0, mk(0, 7, 2, 3, 1'b0));
        step(1, 0, 0, z);           check_time("reset", mk(1, 2, 0, 0, 1'b1));
        step(0, 0, 0, z);           check_time("hold", mk(1, 2, 0, 0, 1'b1));

        step(0, 1, 0, mk(1, 2, 4, 2, 1'b1)); check_time("load_1242", mk(1, 2, 4, 2, 1'b1));
        step(0, 0, 0, z);           check_time("load_held", mk(1, 2, 4, 2, 1'b1));
        step(1, 0, 0, z);           check_time("reset_after_load", mk(1, 2, 0, 0, 1'b1));

        step(0, 1, 0, mk(1, 1, 5, 9, 1'b1)); step(0, 0, 1, z);
        check_time("1159am_to_pm", mk(1, 2, 0, 0, 1'b0));
        step(0, 1, 0, mk(1, 1, 5, 9, 1'b0)); step(0, 0, 1, z);
        check_time("1159pm_to_am", mk(1, 2, 0, 0, 1'b1));
        step(0, 1, 0, mk(1, 2, 5, 9, 1'b0)); step(0, 0, 1, z);
        check_time("1259_to_0100", mk(0, 1, 0, 0, 1'b0));
        step(0, 1, 0, mk(0, 9, 5, 9, 1'b1)); step(0, 0, 1, z);
        check_time("0959_to_1000", mk(1, 0, 0, 0, 1'b1));
        step(0, 1, 0, mk(0, 3, 0, 9, 1'b1)); step(0, 0, 1, z);
        check_time("0309_to_0310", mk(0, 3, 1, 0, 1'b1));

        step(0, 1, 1, mk(0, 5, 3, 0, 1'b0)); check_time("load_beats_min", mk(0, 5, 3, 0, 1'b0));
        step(1, 1, 1, mk(0, 5, 3, 0, 1'b0)); check_time("reset_beats_load", mk(1, 2, 0, 0, 1'b1));

        // out-of-range loads must still roll forward
        step(0, 1, 0, mk(1, 5, 7, 12, 1'b0)); step(0, 0, 1, z);
        check_time("bad_digits_roll", mk(0, 1, 0, 0, 1'b0));
        step(0, 1, 0, mk(0, 0, 5, 9, 1'b1)); step(0, 0, 1, z);
        check_time("hour00_roll", mk(0, 1, 0, 0, 1'b1));

        // full half-day and full day of pulses
        step(1, 0, 0, z);
        for (int i = 0; i < 720; i++) step(0, 0, 1, z);
        check_time("720_pulses", mk(1, 2, 0, 0, 1'b0));
        for (int i = 0; i < 720; i++) step(0, 0, 1, z);
        check_time("1440_pulses", mk(1, 2, 0, 0, 1'b1));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tm_t v;
            int  h;
            bit  r, ld, om;
            r  = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 8);
            om = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 4) == 0) begin
                v = mk($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
            end else begin
                h = $urandom_range(1, 12);
                v = mk(h / 10, h % 10, $urandom_range(0, 5), $urandom_range(0, 9), 1'($urandom));
            end
            step(r, ld, om, v);
        end

        reset = 0; load_new_c = 0; one_minute = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counting_logic.md
Name: counting_logic

Overview:
Time-of-day counter for the alarm-clock datapath. Holds current time as four BCD digits plus an AM flag in 12-hour format (01:00–12:59). Advances one minute per one_minute strobe and accepts a parallel load of a new time from the key/time-set logic. Outputs drive the display mux and alarm comparator.

Parameters:
None.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
new_current_time_ls_min  input  4  BCD load value, minutes units (0–9)
new_current_time_ms_min  input  4  BCD load value, minutes tens (0–5)
new_current_time_ls_hr  input  4  BCD load value, hours units
new_current_time_ms_hr  input  4  BCD load value, hours tens (0–1)
new_current_time_AM  input  1  load value for AM flag (1=AM, 0=PM)
load_new_c  input  1  load enable; high at a clk edge copies new_current_time_* into the counter
one_minute  input  1  minute-advance enable, single-cycle pulse from timebase
current_time_ls_min  output  4  current minutes units
current_time_ms_min  output  4  current minutes tens
current_time_ls_hr  output  4  current hours units
current_time_ms_hr  output  4  current hours tens
current_time_AM  output  1  current AM flag

Positional port order (instantiations connect by position): new_current_time_ls_min, new_current_time_ms_min, new_current_time_ls_hr, new_current_time_ms_hr, new_current_time_AM, load_new_c, reset, clk, one_minute, current_time_ls_min, current_time_ms_min, current_time_ls_hr, current_time_ms_hr, current_time_AM.

Behaviour:
- All outputs are registers; update only at rising clk; no combinational input-to-output path.
- Priority per edge: reset > load_new_c > one_minute > hold.
- reset=1: time := 12:00 AM (ms_hr=1, ls_hr=2, ms_min=0, ls_min=0, AM=1). Visible the cycle after the edge. Reset applied mid-count or mid-load wins unconditionally.
- load_new_c=1 (reset=0): all five fields copied verbatim from new_current_time_*; one_minute ignored that cycle. Held high, load repeats every cycle (counter frozen at load value).
- one_minute=1 (reset=0, load_new_c=0): advance exactly one minute per edge where sampled high; a pulse held N cycles advances N minutes.
- Minute rollover: ls_min 9→0 with carry to ms_min; ms_min 5→0 (at :59) with carry to hour.
- Hour on carry: 12→01 (AM unchanged); 11→12 and AM toggles (11:59 AM→12:00 PM, 11:59 PM→12:00 AM); 09→10; otherwise ls_hr+1.
- No carry: hour and AM hold.
- Out-of-range loaded digits not validated; counting from them must not lock up: ls digit ≥9 treated as 9 (wraps to 0 with carry), ms_min ≥5 treated as 5, hour ≥12 treated as 12 (next 01), hour 00 next 01.
- Latency: 1 clk from sampled control to output change.

Test Plan:
- Assert reset one cycle from arbitrary state → outputs 12:00, AM=1 next cycle; hold with one_minute=0 → unchanged.
- Reset, then load 12:42 AM=1 (ls_min=2, ms_min=4, ls_hr=2, ms_hr=1, load_new_c=1 one cycle) → outputs 12:42 AM=1, held after load_new_c drops; then reset → 12:00 AM=1.
- Load 11:59 AM=1, one one_minute pulse → 12:00 AM=0; load 11:59 AM=0, pulse → 12:00 AM=1.
- Load 12:59 PM, pulse → 01:00 PM; load 09:59, pulse → 10:00; load 03:09, pulse → 03:10.
- Simultaneous load_new_c=1 and one_minute=1 with value 05:30 → 05:30 (no increment); reset=1 with load_new_c=1 → 12:00 AM.
- 720 consecutive one_minute pulses from 12:00 AM → 12:00 PM; 1440 → back to 12:00 AM, every intermediate value legal BCD.
